// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU widths, select codes and the request record type.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W   = 16;
    localparam int ALU_OPW = 3;

    localparam logic [ALU_OPW-1:0] c_ADD = 3'b000;
    localparam logic [ALU_OPW-1:0] c_SUB = 3'b001;
    localparam logic [ALU_OPW-1:0] c_AND = 3'b010;
    localparam logic [ALU_OPW-1:0] c_OR  = 3'b011;
    localparam logic [ALU_OPW-1:0] c_DEC = 3'b100;
    localparam logic [ALU_OPW-1:0] c_INC = 3'b101;
    localparam logic [ALU_OPW-1:0] c_NOT = 3'b110;
    localparam logic [ALU_OPW-1:0] c_XOR = 3'b111;

    typedef struct packed {
        logic [ALU_OPW-1:0] op;
        logic [ALU_W-1:0]   a;
        logic [ALU_W-1:0]   b;
    } alu_req_t;

endpackage
`default_nettype wire

// File: rtl/alu_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_fifo
// Purpose  : Synchronous FIFO of ALU requests with head peek, full/empty/count.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  alu_req_t               push_data,
    input  logic                   pop,
    output alu_req_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    alu_req_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Buffers ALU requests, drives the FIFO head to the combinational
//            ALU and registers result/flags behind a valid/ready handshake.
//            Optional statistics ports enabled by ALU_ISSUE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
`ifdef ALU_ISSUE_STATS_EN
    output logic             out_neg,
    output logic [15:0]      op_count,
    output logic             stall_seen
`else
    output logic             out_neg
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    alu_req_t         w_req;
    alu_req_t         w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_cap;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_carry;
    logic             r_out_zero;
    logic             r_out_neg;

    assign w_req.op = in_op;
    assign w_req.a  = in_a;
    assign w_req.b  = in_b;

    // Full is judged on current occupancy only; a same-cycle pop does not free a slot.
    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_cap    = (w_count != '0) && (!r_out_valid || out_ready);

    alu_req_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_req),
        .pop       (w_cap),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign alu_a   = w_empty ? '0 : w_head.a;
    assign alu_b   = w_empty ? '0 : w_head.b;
    assign alu_sel = w_empty ? '0 : w_head.op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_carry  <= 1'b0;
            r_out_zero   <= 1'b0;
            r_out_neg    <= 1'b0;
        end else if (w_cap) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_res;
            r_out_carry  <= alu_cout;
            r_out_zero   <= (alu_res == '0);
            r_out_neg    <= alu_res[WIDTH-1];
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_carry  = r_out_carry;
    assign out_zero   = r_out_zero;
    assign out_neg    = r_out_neg;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] r_op_count;
    logic        r_stall_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count   <= '0;
            r_stall_seen <= 1'b0;
        end else begin
            if (w_cap) begin
                r_op_count <= r_op_count + 1'b1;
            end
            if (in_valid && !in_ready) begin
                r_stall_seen <= 1'b1;
            end
        end
    end

    assign op_count   = r_op_count;
    assign stall_seen = r_stall_seen;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Scoreboard bench for alu_issue_stage with a behavioural 16-bit ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_res;
    logic        alu_cout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_carry;
    logic        out_zero;
    logic        out_neg;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] op_count;
    logic        stall_seen;
`endif

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b1;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
`ifdef ALU_ISSUE_STATS_EN
        .out_neg    (out_neg),
        .op_count   (op_count),
        .stall_seen (stall_seen)
`else
        .out_neg    (out_neg)
`endif
    );

    // Behavioural stand-in for the downstream combinational ALU.
    logic [16:0] w_t;
    always_comb begin
        w_t      = '0;
        alu_res  = '0;
        alu_cout = 1'b0;
        case (alu_sel)
            c_ADD: begin w_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_res = w_t[15:0]; alu_cout = w_t[16]; end
            c_SUB: begin w_t = {1'b0, alu_a} - {1'b0, alu_b}; alu_res = w_t[15:0]; alu_cout = w_t[16]; end
            c_AND: alu_res = alu_a & alu_b;
            c_OR:  alu_res = alu_a | alu_b;
            c_DEC: alu_res = alu_a - 16'd1;
            c_INC: alu_res = alu_a + 16'd1;
            c_NOT: alu_res = ~alu_a;
            default: alu_res = alu_a ^ alu_b;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && mon_en && out_valid && out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got %h c=%b z=%b n=%b, none expected",
                         out_result, out_carry, out_zero, out_neg);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({out_result, out_carry, out_zero, out_neg} !== e) begin
                    n_err++;
                    $display("FAIL result: got %h c=%b z=%b n=%b, expected %h c=%b z=%b n=%b",
                             out_result, out_carry, out_zero, out_neg, e.r, e.c, e.z, e.n);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic c, input logic z, input logic n,
                        input bit track);
        int waited = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
        end else begin
            if (track) q.push_back('{r: r, c: c, z: z, n: n});
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((out_valid || q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_idle", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {out_result, 13'd0, out_carry, out_zero, out_neg}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_alu_lines", {alu_a, alu_b[12:0], alu_sel}, 32'd0);
        @(posedge clk); #1;

        // Two-cycle latency on a carry-out add that wraps to zero.
        send(c_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        chk("head_alu_a", {16'd0, alu_a}, 32'h0000_FFFF);
        chk("head_alu_sel", {29'd0, alu_sel}, {29'd0, c_ADD});
        @(negedge clk);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        wait_idle();

        send(c_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b1);
        send(c_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(c_OR,  16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b1);
        send(c_INC, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        send(c_DEC, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle();

        // Back-to-back: one result per cycle, order preserved.
        send(c_XOR, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        send(c_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b1);
        send(c_NOT, 16'hFF00, 16'h0000, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("stream_v2", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("stream_v3", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("stream_done", {31'd0, out_valid}, 32'd0);
        wait_idle();

        // Backpressure: five accepted (one in output stage, four queued).
        out_ready = 1'b0;
        send(c_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
        send(c_SUB, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);
        send(c_AND, 16'hFFFF, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        send(c_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(c_XOR, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_op    = c_ADD;
        in_a     = 16'h7777;
        in_b     = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_hold", {15'd0, out_valid, out_result}, 32'h0001_0003);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        chk("drain_end", {31'd0, out_valid}, 32'd0);
        wait_idle();

        // Reset with one pending result and three queued requests.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(c_SUB, 16'h1111, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(c_NOT, 16'h2222, 16'h0002, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(c_XOR, 16'h3333, 16'h0003, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(c_INC, 16'h4444, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        pulse_reset();
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_alu", {alu_a, alu_b[12:0], alu_sel}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end

`ifdef ALU_ISSUE_STATS_EN
        chk("stats_rst_count", {16'd0, op_count}, 32'd0);
        chk("stats_rst_stall", {31'd0, stall_seen}, 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            send(c_ADD, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        wait_idle();
        chk("stats_preload", {16'd0, op_count}, 32'h0000_FFFE);
        mon_en = 1'b1;
        @(posedge clk); #1;
        send(c_ADD, 16'h0007, 16'h0008, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);
        send(c_SUB, 16'h0008, 16'h0007, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        chk("stats_wrap", {16'd0, op_count}, 32'd0);
        chk("stats_no_stall", {31'd0, stall_seen}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(c_INC, 16'(i), 16'h0000, 16'(i + 1), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("stats_stall_set", {31'd0, stall_seen}, 32'd1);
        out_ready = 1'b1;
        wait_idle();
        chk("stats_stall_sticky", {31'd0, stall_seen}, 32'd1);
        @(posedge clk); #1;
        pulse_reset();
        @(negedge clk);
        chk("stats_stall_clr", {31'd0, stall_seen}, 32'd0);
        chk("stats_count_clr", {16'd0, op_count}, 32'd0);
`endif

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand/opcode issue stage placed directly upstream of the team's 16-bit combinational ALU.
- Buffers ALU requests in a small FIFO and drives the head request onto the ALU select and operand lines.
- Registers the ALU result, carry, zero and negative flags into an output stage with valid/ready handshake, so the combinational ALU sits between two register boundaries.

Parameters:
- WIDTH, 16, operand/result width.
- OPW, 3, ALU select width.
- DEPTH, 4, request FIFO entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_op  in  OPW  ALU select code.
- alu_a  out  WIDTH  to ALU operand a (FIFO head).
- alu_b  out  WIDTH  to ALU operand b (FIFO head).
- alu_sel  out  OPW  to ALU select (FIFO head).
- alu_res  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry, bit 0 of the ALU carry output.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  registered result.
- out_carry  out  1  registered carry.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset: FIFO empty (pointers and count 0), out_valid=0, out_result=0, out_carry=0, out_zero=0, out_neg=0, in_ready=1.
- FIFO empty: alu_a, alu_b and alu_sel are driven 0.
- Push: in_valid && in_ready. in_ready = (count != DEPTH). in_ready does not depend on same-cycle pop; the FIFO is full even if a pop occurs that cycle.
- Pop/capture: cap = (count != 0) && (!out_valid || out_ready). On cap, the FIFO head advances and the output registers load alu_res, alu_cout, (alu_res==0) and alu_res[WIDTH-1]; out_valid is set to 1.
- Drain: out_valid && out_ready && !cap clears out_valid. The data registers hold their values.
- Simultaneous push and pop: count unchanged. A push into an empty FIFO is not bypassed to capture in the same cycle.
- Latency:
  - Request accepted at edge N becomes FIFO head after N.
  - It is captured at edge N+1, so out_valid is high in cycle N+1→N+2.
  - Minimum latency is 2 cycles.
  - Sustained throughput is 1 result per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, all out_* are stable and the FIFO head is held.
- Pointers: wrap modulo DEPTH. Count ranges 0..DEPTH.
- Reset mid-operation: all queued requests and any pending result are discarded with no partial output.
- Arithmetic: performed entirely by the ALU. Subtract with a<b yields out_carry=1 (borrow in bit 16). For non-add/sub codes, the ALU drives carry 0 and it passes through unchanged.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined:
  - Adds output port op_count, out, 16 bits.
  - Increments on every cap and wraps 0xFFFF→0x0000.
  - Reset value 0.
  - Adds output port stall_seen, out, 1 bit: a sticky flag set when in_valid && !in_ready, cleared only by rst.
- Undefined: neither port nor the associated logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - ALU select constants: ADD=000, SUB=001, AND=010, OR=011, DEC=100, INC=101, NOT=110, XOR=111.
  - ALU_W=16, ALU_OPW=3.
  - A packed request struct {op, a, b}.
- Sub-module: alu_req_fifo, a parameterised synchronous FIFO of request structs with full/empty/count and head-peek output.
- alu_issue_stage contains the FIFO, the capture logic and the output register.

Test Plan:
- ADD 0xFFFF+0x0001, out_ready=1 → 2 cycles after accept: out_result=0x0000, out_carry=1, out_zero=1, out_neg=0.
- SUB 0x0003−0x0005 → out_result=0xFFFE, out_carry=1, out_neg=1, out_zero=0.
- XOR 0xA5A5^0x5A5A, then NOT of 0x00FF → 0xFFFF (carry 0, neg 1), then 0xFF00; order preserved, one result per cycle.
- out_ready=0, issue 6 requests back-to-back → 5 accepted (1 held in the output stage, 4 in the FIFO), in_ready=0. Results hold stable; releasing out_ready drains 5 results in order on consecutive cycles.
- 3 requests queued and out_valid=1, assert rst for one cycle → next cycle out_valid=0, in_ready=1, alu_a/alu_b/alu_sel=0, and no stale result ever appears.
- ALU_ISSUE_STATS_EN: preload to 0xFFFE via 0xFFFE captures (or force), capture 2 more → op_count=0x0000. Push while full → stall_seen=1 and stays 1 until rst.
